// File: rtl/bu_sched.sv
// Sequencer for the 4-butterfly polynomial processor: NTT, INVNTT, MULT, ADDSUB.
// Latency: NTT/INVNTT 7*(32+PIPE_LAT)+1 cycles start-to-done, MULT/ADDSUB 132+LAT+1.
// Backpressure: none; once started it free-runs, and start is ignored until back in IDLE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, mode, sub         launch pulse; operation select and add/sub, latched on start
//   busy, done               running indicator, one-cycle completion pulse
//   rd_en/rd_sel/rd_addr     data-memory read strobe, bank (0 = A, 1 = B) and word address
//   coef_addr                twiddle ROM address
//   wr_en/wr_addr            write strobe and word address for the processor result
//   bu_*                     processor control: op_mode, stage, type, pre_load, load
//   perf_cycles              busy-cycle counter (only with BU_SCHED_PERF_EN defined)
//
// Optional feature macro: BU_SCHED_PERF_EN.
module bu_sched #(
    parameter int WORDS    = 32,
    parameter int RD_LAT   = 1,
    parameter int PIPE_LAT = 6,
    parameter int MULT_LAT = 9,
    parameter int ADD_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       sub,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic       rd_sel,
    output logic [4:0] rd_addr,
    output logic [7:0] coef_addr,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [1:0] bu_op_mode,
    output logic [2:0] bu_stage,
    output logic       bu_type,
    output logic       bu_pre_load,
    output logic       bu_load
`ifdef BU_SCHED_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    // This revision only supports single-cycle memories and a 32-word polynomial.
    if (RD_LAT != 1 || WORDS != 32) begin : g_param_chk
        $error("bu_sched: unsupported RD_LAT/WORDS");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [1:0] M_NTT  = 2'd0;
    localparam logic [1:0] M_INTT = 2'd1;
    localparam logic [1:0] M_MULT = 2'd2;
    localparam logic [1:0] M_ADD  = 2'd3;

    localparam int DL0 = (PIPE_LAT > MULT_LAT) ? PIPE_LAT : MULT_LAT;
    localparam int DL  = (DL0 > ADD_LAT) ? DL0 : ADD_LAT;

    localparam logic [7:0] WORD_LAST = 8'(WORDS - 1);
    localparam logic [7:0] SLOT_LAST = 8'(4 * (WORDS + 1) - 1);
    localparam logic [5:0] SLOT_RD   = 6'(WORDS);
    // MULT twiddles sit right after the 5*16 + 2*32 NTT twiddles.
    localparam logic [7:0] MULT_COEF = 8'd144;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              sub_q, sub_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        dcnt_q, dcnt_d;
    logic [2:0]        stage_q, stage_d;
    logic [7:0]        coef_q, coef_d;
    logic [DL-1:0]     dl_vld_q, dl_vld_d;
    logic [DL-1:0][4:0] dl_addr_q, dl_addr_d;

    logic       paired;
    logic [2:0] ins_pos;
    logic [4:0] ntt_addr;
    logic [5:0] slot, slot_m1;
    logic [1:0] c;
    logic       issue_vld;
    logic [4:0] issue_addr;
    logic [7:0] drain_last;

    // Place bit t at position b of a 5-bit address built from the 4-bit pair index p.
    function automatic logic [4:0] ins_bit(input logic [3:0] p, input logic [2:0] b,
                                           input logic t);
        logic [4:0] r;
        case (b)
            3'd0:    r = {p, t};
            3'd1:    r = {p[3:1], t, p[0]};
            3'd2:    r = {p[3:2], t, p[1:0]};
            3'd3:    r = {p[3], t, p[2:0]};
            default: r = {t, p};
        endcase
        return r;
    endfunction

    assign slot    = cnt_q[7:2];
    assign c       = cnt_q[1:0];
    assign slot_m1 = slot - 6'd1;

    // Stride selection: NTT halves the stride each stage, INVNTT doubles it.
    always_comb begin
        paired  = 1'b0;
        ins_pos = 3'd0;
        if (mode_q == M_NTT && stage_q <= 3'd4) begin
            paired  = 1'b1;
            ins_pos = 3'd4 - stage_q;
        end else if (mode_q == M_INTT && stage_q >= 3'd1 && stage_q <= 3'd5) begin
            paired  = 1'b1;
            ins_pos = stage_q - 3'd1;
        end
        ntt_addr = paired ? ins_bit(cnt_q[4:1], ins_pos, cnt_q[0]) : cnt_q[4:0];
    end

    // Result latency of the selected operation sets both the write tap and the drain length.
    always_comb begin
        case (mode_q)
            M_MULT: begin
                wr_en      = dl_vld_q[MULT_LAT-1];
                wr_addr    = dl_addr_q[MULT_LAT-1];
                drain_last = 8'(MULT_LAT - 1);
            end
            M_ADD: begin
                wr_en      = dl_vld_q[ADD_LAT-1];
                wr_addr    = dl_addr_q[ADD_LAT-1];
                drain_last = 8'(ADD_LAT - 1);
            end
            default: begin
                wr_en      = dl_vld_q[PIPE_LAT-1];
                wr_addr    = dl_addr_q[PIPE_LAT-1];
                drain_last = 8'(PIPE_LAT - 1);
            end
        endcase
    end

    // Output decode.
    always_comb begin
        busy        = (state_q == RUN) || (state_q == DRAIN);
        done        = (state_q == FIN);
        rd_en       = 1'b0;
        rd_sel      = 1'b0;
        rd_addr     = 5'd0;
        coef_addr   = coef_q;
        bu_op_mode  = mode_q;
        bu_stage    = 3'd0;
        bu_type     = 1'b0;
        bu_pre_load = 1'b0;
        bu_load     = 1'b0;
        issue_vld   = 1'b0;
        issue_addr  = 5'd0;
        if (busy && mode_q == M_ADD) begin
            bu_type = sub_q;
        end
        if (state_q == RUN) begin
            if (!mode_q[1]) begin
                rd_en      = 1'b1;
                rd_addr    = ntt_addr;
                bu_stage   = stage_q;
                bu_type    = paired & cnt_q[0];
                issue_vld  = 1'b1;
                issue_addr = ntt_addr;
            end else begin
                // Slot i fetches word i while the processor works on word i-1.
                if (slot < SLOT_RD) begin
                    case (c)
                        2'd0: begin
                            rd_en   = 1'b1;
                            rd_addr = slot[4:0];
                        end
                        2'd1: bu_pre_load = 1'b1;
                        2'd2: begin
                            rd_en   = 1'b1;
                            rd_sel  = 1'b1;
                            rd_addr = slot[4:0];
                        end
                        default: bu_load = 1'b1;
                    endcase
                end
                if (slot != 6'd0) begin
                    coef_addr  = MULT_COEF + {3'b000, slot_m1[5:1]};
                    issue_addr = slot_m1[4:0];
                    if (mode_q == M_MULT) begin
                        bu_stage  = {1'b0, c};
                        issue_vld = (c == 2'd3);
                    end else begin
                        bu_stage  = (c == 2'd0) ? 3'd0 : 3'd1;
                        issue_vld = (c == 2'd1);
                    end
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sub_d     = sub_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        stage_d   = stage_q;
        coef_d    = coef_q;
        dl_vld_d  = {dl_vld_q[DL-2:0], issue_vld};
        dl_addr_d = {dl_addr_q[DL-2:0], issue_addr};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    sub_d    = sub;
                    cnt_d    = 8'd0;
                    dcnt_d   = 8'd0;
                    stage_d  = 3'd0;
                    coef_d   = 8'd0;
                    // Flush leftovers of the previous operation beyond its own tap.
                    dl_vld_d = '0;
                end
            end
            RUN: begin
                if (!mode_q[1]) begin
                    if (!paired || cnt_q[0]) begin
                        coef_d = coef_q + 8'd1;
                    end
                    if (cnt_q == WORD_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = 8'd0;
                        dcnt_d  = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = 8'd0;
                        dcnt_d  = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (dcnt_q == drain_last) begin
                    dcnt_d = 8'd0;
                    if (!mode_q[1] && stage_q != 3'd6) begin
                        stage_d = stage_q + 3'd1;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            sub_q     <= 1'b0;
            cnt_q     <= 8'd0;
            dcnt_q    <= 8'd0;
            stage_q   <= 3'd0;
            coef_q    <= 8'd0;
            dl_vld_q  <= '0;
            dl_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sub_q     <= sub_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            stage_q   <= stage_d;
            coef_q    <= coef_d;
            dl_vld_q  <= dl_vld_d;
            dl_addr_q <= dl_addr_d;
        end
    end

`ifdef BU_SCHED_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && start) begin
            perf_d = 16'd0;
        end else if (busy) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/bu_sched.md
Name: bu_sched

Overview:
- Sequencer for the 4-butterfly polynomial processor and its coefficient and twiddle memories.
- After one `start` pulse it runs a full 256-coefficient polynomial operation: NTT, INVNTT, pointwise MULT or ADDSUB.
- The polynomial is held as 32 words of 96 bits (8 coefficients per word).
- It drives the processor's op_mode, stage, type, pre_load and load inputs, plus the data-memory read/write addresses and the twiddle ROM address. It then reports completion.

Parameters:
- WORDS, 32, words per polynomial (must be a power of 2).
- RD_LAT, 1, data-memory and ROM read latency in cycles (fixed at 1 in this revision).
- PIPE_LAT, 6, cycles from an NTT/INVNTT read issue to its result word being valid at out_data.
- MULT_LAT, 9, cycles from a MULT stage-3 issue to its full result word being valid.
- ADD_LAT, 2, cycles from an ADDSUB stage-1 issue to its result word being valid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle launch pulse; ignored while busy
- mode  in  2  0 = NTT, 1 = INVNTT, 2 = MULT, 3 = ADDSUB; latched on an accepted start
- sub  in  1  ADDSUB only: 0 = add, 1 = subtract; latched on an accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write
- rd_en  out  1  data-memory read strobe
- rd_sel  out  1  read bank: 0 = operand A / in-place, 1 = operand B
- rd_addr  out  5  read word address
- coef_addr  out  8  twiddle ROM address (24-bit entries, two twiddles each)
- wr_en  out  1  write strobe for out_data
- wr_addr  out  5  write word address
- bu_op_mode  out  2  to processor op_mode
- bu_stage  out  3  to processor stage
- bu_type  out  1  to processor type
- bu_pre_load  out  1  to processor in_buf_pre_load
- bu_load  out  1  to processor in_buf_load

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately; no done pulse is produced and there is no write after the reset edge.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE to RUN on start. The start cycle latches mode and sub; bu_op_mode equals the latched mode while busy.
  - FIN lasts one cycle and asserts done; it then returns to IDLE.
  - A start that arrives in the FIN cycle is ignored.
- Write path (all modes): wr_en and wr_addr come from a delay line.
  - The delay line holds the issue address with its valid bit.
  - Its depth is PIPE_LAT, MULT_LAT or ADD_LAT, selected by mode.
- NTT/INVNTT sequencing:
  - 7 stages, s = 0 to 6. Each stage issues 32 reads, one per cycle (rd_en = 1, rd_sel = 0), with bu_stage = s.
  - The stage then enters DRAIN for PIPE_LAT cycles, which clears the read-after-write hazard. After that the next stage starts, or FIN follows stage 6.
  - Paired stages are NTT stages 0 to 4 with stride 16>>s, and INVNTT stages 1 to 5 with stride 1<<(s-1).
    - Issue n (0 to 31) uses p = n>>1 and bu_type = n[0].
    - rd_addr is p with a 0 bit inserted at bit position log2(stride); when bu_type = 1 that bit is set to 1 instead.
  - All other stages are intra-word: rd_addr = n and bu_type = 0.
  - coef_addr is a counter cleared on start. It increments after each bu_type = 1 issue in paired stages, and after every issue in intra-word stages.
  - coef_addr reaches 144 at completion: 5×16 + 2×32.
  - Total busy time is 7×(32+PIPE_LAT) = 266 cycles, plus the FIN cycle.
- MULT sequencing: 33 slots of 4 cycles each, indexed by c = 0 to 3.
  - In slot i < 32: read A[i] at c = 0, then read B[i] at c = 2 (rd_sel = 1). bu_pre_load is high at c = 1 and bu_load is high at c = 3.
  - In slot i ≥ 1: bu_stage = c for word i-1.
  - coef_addr = 144 + ((i-1)>>1); the processor picks the twiddle half itself.
  - The write-path delay line is loaded at c = 3 of slot i ≥ 1, with address i-1.
  - Slot 32 is read-free; after it comes DRAIN for MULT_LAT cycles, then FIN.
- ADDSUB sequencing: same slot structure as MULT, with bu_stage = c[0] for c = 0 and 1.
  - bu_type = sub.
  - At c = 2 and 3, bu_stage holds 1 and no new issue is made.
  - The write-path delay line is loaded at c = 1; DRAIN lasts ADD_LAT cycles.
- Simultaneous start and an in-progress operation: start is ignored and the latched mode is unchanged.
- Address counters wrap modulo WORDS only at stage or slot boundaries; they never wrap inside a stage.

Optional Feature:
- Macro: BU_SCHED_PERF_EN.
- With the macro defined:
  - Adds output perf_cycles, 16 bits.
  - The counter clears on an accepted start and increments every busy cycle.
  - It holds its value after done until the next start, and resets to 0.
- Without the macro: the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
- NTT: start with mode = 0 → 224 rd_en cycles. Stage 0 rd_addr runs 0, 16, 1, 17, … and coef_addr ends at 144. Exactly 224 wr_en, done at cycle 267, and perf_cycles = 266.
- INVNTT stage 1 issue order: rd_addr runs 0, 1, 2, 3, … with bu_type toggling 0/1. Stage 5 runs 0, 16, 1, 17, … with no write to a word before its drain completes.
- MULT: start with mode = 2 → bu_pre_load and bu_load fire 32 times each. bu_stage runs 0 to 3 repeatedly from cycle 4. wr_addr runs 0 to 31 in order, and done comes after 132+MULT_LAT cycles.
- ADDSUB with sub = 1: bu_type is held at 1 throughout and there are 32 writes in order.
- Assert rst at cycle 50 of an NTT → all outputs are 0 on the next cycle, with no done pulse and no wr_en afterwards. A new start then runs normally.
- A start pulse mid-run with a different mode → it is ignored, bu_op_mode is unchanged and the write count is unchanged.
